weight_replay_buffer: RTL and testbench

- Sits directly downstream of a weight source (ROM-backed parameter streamer) and upstream of the linear/matmul datapath.
- Captures one full weight tensor, streamed as DEPTH beats of PARALLELISM words, over a valid/ready handshake into internal storage.
- Replays the stored tensor REPEAT times to the consumer, so one weight fetch serves several activation rows.
- Then returns to capture the next tensor.

---
 rtl/weight_replay_buffer.sv | 142 ++++++++++++++
 tb/tb_weight_replay_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_replay_buffer.sv
// weight_replay_buffer
// Captures one weight tensor (DEPTH beats of PARALLELISM words) from the
// weight streamer, then replays it REPEAT times to the matmul datapath
// before accepting the next tensor. Every output is driven from a register.
module weight_replay_buffer #(
   parameter int DATA_WIDTH  = 16,
   parameter int PARALLELISM = 1,
   parameter int DEPTH       = 32,
   parameter int REPEAT      = 4,
   parameter int PTR_WIDTH   = $clog2(DEPTH) + 1,
   parameter int REP_WIDTH   = $clog2(REPEAT) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in [PARALLELISM],
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out [PARALLELISM],
   output logic                  data_out_valid,
   input  logic                  data_out_ready,
   output logic                  tensor_done,
   output logic                  busy
);

   localparam int WORD_W = PARALLELISM * DATA_WIDTH;
   // storage address width; a single-entry memory still takes a 1-bit index
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] FILL   = 1'b0;
   localparam logic [0:0] REPLAY = 1'b1;

   localparam logic [PTR_WIDTH-1:0] LAST_BEAT = PTR_WIDTH'(DEPTH - 1);
   localparam logic [REP_WIDTH-1:0] LAST_REP  = REP_WIDTH'(REPEAT - 1);

   logic [0:0]            r_state;
   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [REP_WIDTH-1:0]  r_rep;
   // set once the final beat of the final replay sits in the output register
   logic                  r_all_issued;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_done;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_dout [PARALLELISM];
   logic [WORD_W-1:0]     r_mem [DEPTH];

   logic [WORD_W-1:0]     w_din_flat;
   logic [WORD_W-1:0]     w_rd_flat;
   logic                  w_in_hs;
   logic                  w_out_hs;
   logic                  w_load;

   // flatten the input lanes into one storage word, lane 0 in the low bits
   always_comb begin
      w_din_flat = '0;
      for (int i = 0; i < PARALLELISM; i++)
         w_din_flat[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i];
   end

   assign w_rd_flat = r_mem[r_rd_ptr[AW-1:0]];
   assign w_in_hs   = (r_state == FILL) && data_in_valid && r_in_ready;
   assign w_out_hs  = r_out_valid && data_out_ready;
   // refill the output register when it is empty or being drained
   assign w_load    = (r_state == REPLAY) && !r_all_issued &&
                      (!r_out_valid || data_out_ready);

   // tensor storage: written only during capture, never reset
   always_ff @(posedge clk) begin
      if (w_in_hs)
         r_mem[r_wr_ptr[AW-1:0]] <= w_din_flat;
   end

   // capture / replay control and the registered output stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= FILL;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_rep        <= '0;
         r_all_issued <= 1'b0;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         for (int i = 0; i < PARALLELISM; i++)
            r_dout[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            FILL: begin
               if (w_in_hs) begin
                  if (r_wr_ptr == LAST_BEAT) begin
                     r_wr_ptr     <= '0;
                     r_in_ready   <= 1'b0;
                     r_state      <= REPLAY;
                     r_rd_ptr     <= '0;
                     r_rep        <= '0;
                     r_all_issued <= 1'b0;
                     r_busy       <= 1'b1;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                  end
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            REPLAY: begin
               if (w_out_hs && r_all_issued) begin
                  // final beat of final replay handed over
                  r_out_valid  <= 1'b0;
                  r_state      <= FILL;
                  r_busy       <= 1'b0;
                  r_in_ready   <= 1'b1;
                  r_done       <= 1'b1;
                  r_all_issued <= 1'b0;
               end else if (w_load) begin
                  r_out_valid <= 1'b1;
                  for (int i = 0; i < PARALLELISM; i++)
                     r_dout[i] <= w_rd_flat[i*DATA_WIDTH +: DATA_WIDTH];
                  if (r_rd_ptr == LAST_BEAT) begin
                     r_rd_ptr <= '0;
                     r_rep    <= r_rep + 1'b1;
                     if (r_rep == LAST_REP)
                        r_all_issued <= 1'b1;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign data_in_ready  = r_in_ready;
   assign data_out       = r_dout;
   assign data_out_valid = r_out_valid;
   assign tensor_done    = r_done;
   assign busy           = r_busy;

endmodule

// File: tb/tb_weight_replay_buffer.sv
// Bench for weight_replay_buffer: DEPTH=4/REPEAT=3/P=1 instance checked every
// cycle against a beat-count model, plus a DEPTH=1/REPEAT=1/P=4 instance.
module tb_weight_replay_buffer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] a_din [1];
   logic        a_vin, a_rin;
   logic [15:0] a_dout [1];
   logic        a_vout, a_rout, a_done, a_busy;

   logic [15:0] b_din [4];
   logic        b_vin, b_rin;
   logic [15:0] b_dout [4];
   logic        b_vout, b_rout, b_done, b_busy;

   weight_replay_buffer #(.DATA_WIDTH(16), .PARALLELISM(1), .DEPTH(4), .REPEAT(3)) u_a (
      .clk(clk), .rst(rst),
      .data_in(a_din), .data_in_valid(a_vin), .data_in_ready(a_rin),
      .data_out(a_dout), .data_out_valid(a_vout), .data_out_ready(a_rout),
      .tensor_done(a_done), .busy(a_busy));

   weight_replay_buffer #(.DATA_WIDTH(16), .PARALLELISM(4), .DEPTH(1), .REPEAT(1)) u_b (
      .clk(clk), .rst(rst),
      .data_in(b_din), .data_in_valid(b_vin), .data_in_ready(b_rin),
      .data_out(b_dout), .data_out_valid(b_vout), .data_out_ready(b_rout),
      .tensor_done(b_done), .busy(b_busy));

   int nerr = 0;
   int nchk = 0;
   int cyc  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // model: a tensor is 4 captured beats; replay emits beat (n mod 4) for n = 0..11
   localparam int D = 4;
   localparam int R = 3;
   logic [15:0] m_store [D];
   int          m_nfill  = 0;
   int          m_issued = 0;
   bit          m_ready = 0, m_busy = 0, m_vld = 0, m_done = 0;
   logic [15:0] m_dout = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_nfill = 0; m_issued = 0; m_ready = 0; m_busy = 0;
         m_vld = 0; m_done = 0; m_dout = '0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (m_ready && a_vin) begin
               m_store[m_nfill] = a_din[0];
               m_nfill++;
               if (m_nfill == D) begin
                  m_nfill = 0; m_busy = 1; m_ready = 0; m_issued = 0;
               end
            end else begin
               m_ready = 1;
            end
         end else if (m_vld && a_rout && m_issued == D*R) begin
            m_vld = 0; m_busy = 0; m_ready = 1; m_done = 1;
         end else if ((!m_vld || a_rout) && m_issued < D*R) begin
            m_dout = m_store[m_issued % D];
            m_vld = 1;
            m_issued++;
         end
      end
   end

   // per-cycle compare plus event logs for the directed checks
   logic [15:0] hs_q [$];
   int          hs_c [$];
   int          done_c [$];
   int          acc_c [$];
   int          first_v = -1;
   bit          rdy_at_done = 0;

   always @(negedge clk) begin
      cyc++;
      chk("in_ready", a_rin, m_ready);
      chk("out_valid", a_vout, m_vld);
      chk("busy", a_busy, m_busy);
      chk("tensor_done", a_done, m_done);
      chk("data_out", a_dout[0], m_dout);
      if (rst) begin
         if (a_vout && a_rout) begin hs_q.push_back(a_dout[0]); hs_c.push_back(cyc); end
         if (a_done) begin done_c.push_back(cyc); rdy_at_done = a_rin; end
         if (a_vin && a_rin) acc_c.push_back(cyc);
         if (a_vout && first_v < 0) first_v = cyc;
      end
   end

   // consumer ready: always 1, or the repeating pattern 1,0,0,1
   int rmode = 0;
   int rk = 0;
   initial begin
      a_rout = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rmode == 1) begin
            a_rout = (rk % 4 == 0) || (rk % 4 == 3);
            rk++;
         end else begin
            a_rout = 1'b1;
         end
      end
   end

   task automatic clear_logs();
      hs_q.delete(); hs_c.delete(); done_c.delete(); acc_c.delete();
      first_v = -1; rdy_at_done = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // present four beats; gap=1 uses upstream valid pattern 1,0,1,0,0,1,1
   task automatic send4(input logic [15:0] w0, w1, w2, w3, input bit gap,
                        output int ncyc, output int bub_rdy);
      logic [15:0] w [4];
      bit pat [7];
      int idx, k;
      bit acc;
      w = '{w0, w1, w2, w3};
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      idx = 0; k = 0; bub_rdy = 0;
      a_vin = gap ? pat[0] : 1'b1;
      a_din[0] = w[0];
      while (idx < 4 && k < 300) begin
         @(negedge clk);
         acc = a_vin && a_rin;
         if (!a_vin && a_rin) bub_rdy++;
         tick();
         if (acc) idx++;
         k++;
         a_vin = (idx < 4) ? (gap ? pat[k % 7] : 1'b1) : 1'b0;
         a_din[0] = w[idx % 4];
      end
      ncyc = k;
      chk("send_accepted", idx, 4);
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_c.size() < n && t < 500) begin tick(); t++; end
      chk("done_seen", done_c.size() >= n, 1);
      tick();
   endtask

   task automatic check_seq(input string nm, input int off,
                            input logic [15:0] w0, w1, w2, w3);
      logic [15:0] w [4];
      w = '{w0, w1, w2, w3};
      chk({nm, "_len"}, hs_q.size() >= off + 12, 1);
      for (int j = 0; j < 12; j++)
         if (off + j < hs_q.size()) chk(nm, hs_q[off+j], w[j%4]);
   endtask

   int ncyc, bub;
   int t;

   initial begin
      a_vin = 0; a_din[0] = '0;
      b_vin = 0; b_rout = 1'b1;
      for (int i = 0; i < 4; i++) b_din[i] = '0;
      repeat (3) tick();
      chk("rst_in_ready", a_rin, 0);
      chk("rst_out_valid", a_vout, 0);
      rst = 1'b1;
      tick(); tick();
      chk("ready_after_release", a_rin, 1);

      // 1: basic capture and 3 replays with ready held high
      clear_logs();
      send4(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, ncyc, bub);
      wait_done(1);
      check_seq("seq_basic", 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      chk("first_latency", first_v - acc_c[3], 2);
      chk("no_gaps", hs_c[11] - hs_c[0], 11);
      chk("done_count", done_c.size(), 1);
      chk("done_after_last", done_c[0] - hs_c[11], 1);
      chk("ready_with_done", rdy_at_done, 1);

      // 2: consumer backpressure 1,0,0,1
      clear_logs();
      rk = 0; rmode = 1;
      send4(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, ncyc, bub);
      wait_done(1);
      rmode = 0;
      check_seq("seq_stall", 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      chk("stall_beats", hs_q.size(), 12);

      // 3: upstream bubbles
      clear_logs();
      send4(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1, ncyc, bub);
      chk("bubble_cycles", ncyc, 7);
      chk("bubble_ready", bub, 3);
      wait_done(1);
      check_seq("seq_bubble", 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);

      // 4: reset during replay beat 6, then a fresh tensor
      clear_logs();
      send4(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, ncyc, bub);
      t = 0;
      while (hs_q.size() < 5 && t < 100) begin tick(); t++; end
      chk("reached_beat6", hs_q.size(), 5);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", a_rin, 0);
      chk("mid_rst_valid", a_vout, 0);
      chk("mid_rst_data", a_dout[0], 0);
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_done", a_done, 0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      chk("ready_after_rst", a_rin, 1);
      clear_logs();
      send4(16'h000A, 16'h000B, 16'h000C, 16'h000D, 0, ncyc, bub);
      wait_done(1);
      check_seq("seq_after_rst", 0, 16'h000A, 16'h000B, 16'h000C, 16'h000D);

      // 5: back-to-back tensors
      clear_logs();
      send4(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, ncyc, bub);
      send4(16'h1001, 16'h1002, 16'h1003, 16'h1004, 0, ncyc, bub);
      wait_done(2);
      chk("t1_after_done", acc_c[4] >= done_c[0], 1);
      check_seq("seq_t0", 0, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      check_seq("seq_t1", 12, 16'h1001, 16'h1002, 16'h1003, 16'h1004);

      // 6: DEPTH=1 REPEAT=1 P=4 pass-through
      begin
         int c_acc, c_out, c_done, nout;
         logic [15:0] got [4];
         bit hsb;
         c_acc = -1; c_out = -1; c_done = -1; nout = 0;
         for (int i = 0; i < 4; i++) got[i] = '0;
         b_din = '{16'd1, 16'd2, 16'd3, 16'd4};
         b_vin = 1'b1;
         @(negedge clk);
         hsb = b_vin && b_rin;
         c_acc = cyc;
         tick();
         b_vin = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_vout && b_rout) begin
               nout++; c_out = cyc;
               for (int i = 0; i < 4; i++) got[i] = b_dout[i];
            end
            if (b_done) c_done = cyc;
            tick();
         end
         chk("b_accept", hsb, 1);
         chk("b_beats", nout, 1);
         chk("b_latency", c_out - c_acc, 2);
         chk("b_done_pos", c_done - c_out, 1);
         for (int i = 0; i < 4; i++) chk("b_lane", got[i], 16'(i + 1));
         chk("b_ready_back", b_rin, 1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
